// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic MAC array control path.
package tpu_pkg;
  localparam int DATA_SIZE = 8;

  localparam logic INSTR_COMPUTE = 1'b0;
  localparam logic INSTR_HOLD    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } seq_state_e;
endpackage

// File: rtl/mac_array_sequencer_if.sv
// Host command, SRAM strobe and array control bundle of the MAC array sequencer.
interface mac_array_sequencer_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 16
);
  localparam int SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   start;
  logic [LEN_W-1:0]       cfg_len;
  logic                   stall;
  logic                   busy;
  logic                   done;
  logic                   wgt_rd_en;
  logic [LEN_W-1:0]       wgt_rd_addr;
  logic                   weight_load_en;
  logic [SEL_W-1:0]       weight_row_sel;
  logic                   act_rd_en;
  logic [LEN_W-1:0]       act_rd_addr;
  logic [ROWS-1:0]        row_valid;
  logic                   array_instr;
  logic                   array_en;
  logic [COLS-1:0]        res_wr_en;
  logic [COLS*LEN_W-1:0]  res_wr_addr;
  logic [31:0]            mac_matrix_counter;

  modport master (
    output start, cfg_len, stall,
    input  busy, done, wgt_rd_en, wgt_rd_addr, weight_load_en, weight_row_sel,
           act_rd_en, act_rd_addr, row_valid, array_instr, array_en,
           res_wr_en, res_wr_addr, mac_matrix_counter
  );

  modport slave (
    input  start, cfg_len, stall,
    output busy, done, wgt_rd_en, wgt_rd_addr, weight_load_en, weight_row_sel,
           act_rd_en, act_rd_addr, row_valid, array_instr, array_en,
           res_wr_en, res_wr_addr, mac_matrix_counter
  );
endinterface

// File: rtl/skew_delay_line.sv
// Enable-gated shift register; o_taps[i] is i_data delayed by TAP_FIRST+1+i enabled cycles.
module skew_delay_line #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 1,
  parameter int TAP_FIRST = 0
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     i_en,
  input  logic [WIDTH-1:0]                         i_data,
  output logic [DEPTH-TAP_FIRST-1:0][WIDTH-1:0]    o_taps
);
  logic [DEPTH-1:0][WIDTH-1:0] r_stage_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stage_p1 <= '0;
    end else if (i_en) begin
      r_stage_p1[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage_p1[i] <= r_stage_p1[i-1];
      end
    end
  end

  assign o_taps = r_stage_p1[DEPTH-1:TAP_FIRST];
endmodule

// File: rtl/mac_array_sequencer.sv
// Job controller for the ROWSxCOLS systolic array: weight load, skewed activation stream,
// south-edge drain and result write-back, with a global stall freeze.
module mac_array_sequencer
  import tpu_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  mac_array_sequencer_if.slave  bus
);
  localparam int SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [LEN_W-1:0] LOAD_LAST  = LEN_W'(ROWS);
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(ROWS + COLS - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [31:0]       r_mac_cnt;
  logic              w_run;
  logic              w_wgt_rd, w_wload, w_act_rd, w_compute;
  logic [LEN_W:0]    w_issue_p0;
  logic [ROWS-1:0][0:0]    w_row_taps;
  logic [COLS-1:0][LEN_W:0] w_res_taps;
  logic [COLS-1:0]         w_res_en;
  logic [COLS*LEN_W-1:0]   w_res_addr;

  assign w_run = ~bus.stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_mac_cnt <= '0;
    end else if (w_run) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && bus.start) begin
        r_len     <= bus.cfg_len;
        r_mac_cnt <= '0;
      end else if (r_state != IDLE && r_mac_cnt != '1) begin
        r_mac_cnt <= r_mac_cnt + 32'd1;
      end
    end
  end

  // LOAD_W spends ROWS+1 cycles so the last weight row, read in cycle ROWS-1, is latched in cycle ROWS.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wgt_rd    = 1'b0;
    w_wload     = 1'b0;
    w_act_rd    = 1'b0;
    w_compute   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (bus.cfg_len == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        w_wgt_rd = (r_cnt < LOAD_LAST);
        w_wload  = (r_cnt != '0);
        if (r_cnt == LOAD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STREAM;
        end else begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
        end
      end
      STREAM: begin
        w_act_rd  = 1'b1;
        w_compute = 1'b1;
        if (r_cnt == r_len - LEN_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
        end
      end
      DRAIN: begin
        w_compute = 1'b1;
        if (r_cnt == DRAIN_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0: issued activation index enters the west-edge skew and the south-edge result pipelines.
  assign w_issue_p0 = {w_act_rd, (w_act_rd ? r_cnt : '0)};

  skew_delay_line #(.WIDTH(1), .DEPTH(ROWS), .TAP_FIRST(0)) u_row_skew (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_run),
    .i_data (w_act_rd),
    .o_taps (w_row_taps)
  );

  skew_delay_line #(.WIDTH(LEN_W + 1), .DEPTH(ROWS + COLS), .TAP_FIRST(ROWS)) u_res_pipe (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_run),
    .i_data (w_issue_p0),
    .o_taps (w_res_taps)
  );

  // Stage p1: column j sees vector t at issue+ROWS+1+j.
  always_comb begin
    w_res_en   = '0;
    w_res_addr = '0;
    for (int j = 0; j < COLS; j++) begin
      w_res_en[j]                   = w_res_taps[j][LEN_W] & w_run;
      w_res_addr[j*LEN_W +: LEN_W]  = w_res_taps[j][LEN_W-1:0];
    end
  end

  assign bus.busy               = (r_state != IDLE);
  assign bus.done               = (r_state == DONE) & w_run;
  assign bus.wgt_rd_en          = w_wgt_rd & w_run;
  assign bus.wgt_rd_addr        = w_wgt_rd ? r_cnt : '0;
  assign bus.weight_load_en     = w_wload & w_run;
  assign bus.weight_row_sel     = w_wload ? SEL_W'(r_cnt - LEN_W'(1)) : '0;
  assign bus.act_rd_en          = w_act_rd & w_run;
  assign bus.act_rd_addr        = w_act_rd ? r_cnt : '0;
  assign bus.row_valid          = w_row_taps;
  assign bus.array_instr        = (w_compute & w_run) ? INSTR_COMPUTE : INSTR_HOLD;
  assign bus.array_en           = w_run;
  assign bus.res_wr_en          = w_res_en;
  assign bus.res_wr_addr        = w_res_addr;
  assign bus.mac_matrix_counter = r_mac_cnt;
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer (ROWS=COLS=4, LEN_W=16); r counts cycles after the start cycle.
module tb_mac_array_sequencer;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_array_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) bus ();

  mac_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wgt_en;
    logic [15:0] wgt_addr;
    logic        wl_en;
    logic [1:0]  wl_sel;
    logic        act_en;
    logic [15:0] act_addr;
    logic [3:0]  row_vld;
    logic        instr;
    logic [3:0]  res_en;
    logic [63:0] res_addr;
    logic [31:0] mcnt;
  } obs_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.busy     = bus.busy;
    o.done     = bus.done;
    o.wgt_en   = bus.wgt_rd_en;
    o.wgt_addr = bus.wgt_rd_addr;
    o.wl_en    = bus.weight_load_en;
    o.wl_sel   = bus.weight_row_sel;
    o.act_en   = bus.act_rd_en;
    o.act_addr = bus.act_rd_addr;
    o.row_vld  = bus.row_valid;
    o.instr    = bus.array_instr;
    o.res_en   = bus.res_wr_en;
    o.res_addr = bus.res_wr_addr;
    o.mcnt     = bus.mac_matrix_counter;
    return o;
  endfunction

  // Nominal job timeline: LOAD_W r=1..5, STREAM r=6..5+n, DRAIN r=6+n..13+n, DONE r=14+n.
  function automatic obs_t exp_at(int n, int r);
    obs_t e;
    int   i;
    e       = '0;
    e.instr = 1'b1;
    e.mcnt  = 32'(r - 1);
    if (n == 0) begin
      e.busy = (r == 1);
      e.done = (r == 1);
      return e;
    end
    e.busy = (r >= 1 && r <= 14 + n);
    e.done = (r == 14 + n);
    if (r >= 1 && r <= 4) begin e.wgt_en = 1'b1; e.wgt_addr = 16'(r - 1); end
    if (r >= 2 && r <= 5) begin e.wl_en = 1'b1; e.wl_sel = 2'(r - 2); end
    if (r >= 6 && r <= 5 + n) begin e.act_en = 1'b1; e.act_addr = 16'(r - 6); end
    if (r >= 6 && r <= 13 + n) e.instr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i = r - 1 - k;
      if (i >= 6 && i <= 5 + n) e.row_vld[k] = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      i = r - 5 - j;
      if (i >= 6 && i <= 5 + n) begin
        e.res_en[j] = 1'b1;
        e.res_addr[j*16 +: 16] = 16'(i - 6);
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    obs_t a, e;
    e = '0;
    e.instr = 1'b1;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.stall = 1'b0;
    tick();
    tick();
    @(negedge clk);
    a = sample();
    n_total++;
    if (a !== e) $display("FAIL reset_hold actual=%h required=%h", a, e); else n_pass++;
    n_total++;
    if (bus.array_en !== 1'b1) $display("FAIL reset_array_en actual=%b required=1", bus.array_en); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    a = sample();
    n_total++;
    if (a !== e) $display("FAIL reset_idle actual=%h required=%h", a, e); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_len3();
    obs_t a, e;
    int dones = 0, w3 = 0;
    logic [15:0] last3 = 16'hffff;
    bus.cfg_len = 16'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 1; r <= 18; r++) begin
      @(negedge clk);
      a = sample();
      e = exp_at(3, r);
      n_total++;
      if (a !== e) $display("FAIL len3_r%0d actual=%h required=%h", r, a, e); else n_pass++;
      if (bus.done) dones++;
      if (bus.res_wr_en[3]) begin w3++; last3 = bus.res_wr_addr[63:48]; end
      @(posedge clk); #1;
    end
    n_total++;
    if (dones != 1) $display("FAIL len3_done_count actual=%0d required=1", dones); else n_pass++;
    n_total++;
    if (w3 != 3) $display("FAIL len3_col3_writes actual=%0d required=3", w3); else n_pass++;
    n_total++;
    if (last3 !== 16'd2) $display("FAIL len3_col3_last_addr actual=%0d required=2", last3); else n_pass++;
    n_total++;
    if (bus.mac_matrix_counter !== 32'd17) $display("FAIL len3_counter_hold actual=%0d required=17", bus.mac_matrix_counter); else n_pass++;
  endtask

  task automatic test_single_len1();
    obs_t a, e;
    int onehot = 0;
    bus.cfg_len = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      a = sample();
      e = exp_at(1, r);
      n_total++;
      if (a !== e) $display("FAIL len1_r%0d actual=%h required=%h", r, a, e); else n_pass++;
      if (r >= 7 && r <= 10 && bus.row_valid == 4'(1 << (r - 7))) onehot++;
      @(posedge clk); #1;
    end
    n_total++;
    if (onehot != 4) $display("FAIL len1_row_walk actual=%0d required=4", onehot); else n_pass++;
  endtask

  task automatic test_zero_len();
    obs_t a, e;
    logic any_en = 1'b0;
    bus.cfg_len = 16'd0;
    bus.start = 1'b1;
    @(negedge clk);
    any_en = bus.wgt_rd_en | bus.weight_load_en | bus.act_rd_en | (|bus.res_wr_en);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      any_en = any_en | bus.wgt_rd_en | bus.weight_load_en | bus.act_rd_en | (|bus.res_wr_en);
      if (r <= 2) begin
        a = sample();
        e = exp_at(0, r);
        n_total++;
        if (a !== e) $display("FAIL len0_r%0d actual=%h required=%h", r, a, e); else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_total++;
    if (any_en !== 1'b0) $display("FAIL len0_no_enables actual=%b required=0", any_en); else n_pass++;
  endtask

  task automatic test_stall();
    obs_t a, e;
    int eff;
    bus.cfg_len = 16'd4;
    bus.start = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL stall_start_not_taken actual=%b required=0", bus.busy); else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int w = 1; w <= 22; w++) begin
      bus.stall = (w >= 7 && w <= 9);
      eff = (w < 7) ? w : ((w < 10) ? 7 : w - 3);
      e = exp_at(4, eff);
      if (bus.stall) begin
        e.done = 1'b0; e.wgt_en = 1'b0; e.wl_en = 1'b0;
        e.act_en = 1'b0; e.res_en = '0; e.instr = 1'b1;
      end
      @(negedge clk);
      a = sample();
      n_total++;
      if (a !== e) $display("FAIL stall_w%0d actual=%h required=%h", w, a, e); else n_pass++;
      if (w == 9) begin
        n_total++;
        if (bus.act_rd_addr !== 16'd1 || bus.mac_matrix_counter !== 32'd6 || bus.array_en !== 1'b0)
          $display("FAIL stall_frozen actual=addr %0d cnt %0d en %b required=addr 1 cnt 6 en 0",
                   bus.act_rd_addr, bus.mac_matrix_counter, bus.array_en);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    obs_t a, e, z;
    logic stray = 1'b0;
    z = '0;
    z.instr = 1'b1;
    bus.cfg_len = 16'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      if (r == 10) rst = 1'b1;
      @(negedge clk);
      a = sample();
      e = exp_at(2, r);
      n_total++;
      if (a !== e) $display("FAIL rstdrain_r%0d actual=%h required=%h", r, a, e); else n_pass++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    a = sample();
    n_total++;
    if (a !== z) $display("FAIL rstdrain_cleared actual=%h required=%h", a, z); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      stray = stray | bus.done | bus.busy | bus.wgt_rd_en | bus.act_rd_en | (|bus.res_wr_en);
    end
    n_total++;
    if (stray !== 1'b0) $display("FAIL rstdrain_quiet actual=%b required=0", stray); else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 1; r <= 17; r++) begin
      @(negedge clk);
      a = sample();
      e = exp_at(2, r);
      n_total++;
      if (a !== e) $display("FAIL rerun_r%0d actual=%h required=%h", r, a, e); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t a, e;
    int dones = 0;
    bus.cfg_len = 16'd1;
    bus.start = 1'b1;
    tick();
    for (int w = 1; w <= 31; w++) begin
      @(negedge clk);
      a = sample();
      e = (w <= 16) ? exp_at(1, w) : exp_at(1, w - 16);
      n_total++;
      if (a !== e) $display("FAIL b2b_w%0d actual=%h required=%h", w, a, e); else n_pass++;
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_final_idle actual=%b required=0", bus.busy); else n_pass++;
    n_total++;
    if (dones != 2) $display("FAIL b2b_done_count actual=%0d required=2", dones); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_len3();
    test_single_len1();
    test_zero_len();
    test_stall();
    test_reset_in_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
